// File: rtl/elem_smul_by_row_seq.sv
// -----------------------------------------------------------------------------
// elem_smul_by_row_seq
//   Sequential element-by-element signed fixed-point multiply of a ROWS x COLS
//   matrix by a row vector: f[r][c] = (a[r][c] * b[c]) >>> SCALE.
//   A single shared multiplier handles one element per clock. Operands are
//   latched on an accepted start, elements are issued row-major (c fastest)
//   into a one-deep product register and written into f one edge later.
//
//   Optional feature macro: ELEM_SMUL_SAT_EN
//     defined   : results outside the WIDTH-bit signed range clamp to the
//                 nearest limit and raise the sticky ovf flag (cleared by the
//                 next accepted start).
//     undefined : results keep the low WIDTH bits (wrap); ovf is tied 0.
//
// Ports
//   clk    in   clock, all state on the rising edge
//   rst    in   asynchronous active-high reset
//   start  in   operation request, sampled only while busy=0
//   a      in   [ROWS:1][COLS:1][WIDTH] matrix operand, latched on start
//   b      in   [COLS:1][WIDTH] row operand, latched on start
//   f      out  [ROWS:1][COLS:1][WIDTH] registered result matrix
//   busy   out  operation in progress
//   done   out  one-cycle pulse, all of f valid
//   ovf    out  sticky overflow flag of the current operation
// -----------------------------------------------------------------------------
module elem_smul_by_row_seq #(
   parameter int ROWS  = 1,
   parameter int COLS  = 1,
   parameter int WIDTH = 32,
   parameter int SCALE = 16
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic [ROWS:1][COLS:1][WIDTH-1:0]    a,
   input  logic [COLS:1][WIDTH-1:0]            b,
   output logic [ROWS:1][COLS:1][WIDTH-1:0]    f,
   output logic                                busy,
   output logic                                done,
   output logic                                ovf
);

   // Counters must hold ROWS+1 because r steps past the last row on the
   // final issue; it is reloaded on the next accepted start.
   localparam int RW = $clog2(ROWS + 1);
   localparam int CW = $clog2(COLS + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                             state_reg, state_next;
   logic                               accept;
   logic                               last_issue;

   logic [ROWS:1][COLS:1][WIDTH-1:0]   a_reg;
   logic [COLS:1][WIDTH-1:0]           b_reg;
   logic [RW-1:0]                      r_reg;
   logic [CW-1:0]                      c_reg;

   logic [WIDTH-1:0]                   prod_reg;
   logic [RW-1:0]                      wr_r_reg;
   logic [CW-1:0]                      wr_c_reg;
   logic                               wr_valid_reg;
   logic                               done_reg;
   logic [ROWS:1][COLS:1][WIDTH-1:0]   f_reg;

   logic signed [WIDTH-1:0]            elem_a, elem_b;
   logic signed [2*WIDTH-1:0]          prod_full, prod_sh;
   logic [WIDTH-1:0]                   res_now;

   assign last_issue = (r_reg == RW'(ROWS)) && (c_reg == CW'(COLS));

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = RUN;
            end
         end
         RUN:     if (last_issue) state_next = DRAIN;
         DRAIN:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---------------------------------------------------------- arithmetic
   // Operands are sign-extended to 2*WIDTH so the product is exact.
   always_comb begin
      elem_a    = a_reg[r_reg][c_reg];
      elem_b    = b_reg[c_reg];
      prod_full = $signed({{WIDTH{elem_a[WIDTH-1]}}, elem_a}) *
                  $signed({{WIDTH{elem_b[WIDTH-1]}}, elem_b});
      prod_sh   = prod_full >>> SCALE;
   end

`ifdef ELEM_SMUL_SAT_EN
   localparam logic signed [2*WIDTH-1:0] MAX_V = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [2*WIDTH-1:0] MIN_V = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   logic ovf_now;
   logic ovf_reg;

   always_comb begin
      ovf_now = (prod_sh > MAX_V) || (prod_sh < MIN_V);
      if (!ovf_now)          res_now = prod_sh[WIDTH-1:0];
      else if (prod_sh[2*WIDTH-1]) res_now = {1'b1, {(WIDTH-1){1'b0}}};
      else                   res_now = {1'b0, {(WIDTH-1){1'b1}}};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                     ovf_reg <= 1'b0;
      else if (accept)             ovf_reg <= 1'b0;
      else if (state_reg == RUN)   ovf_reg <= ovf_reg | ovf_now;
   end

   assign ovf = ovf_reg;
`else
   assign res_now = prod_sh[WIDTH-1:0];
   assign ovf     = 1'b0;
`endif

   // ------------------------------------------------------------ datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg        <= '0;
         b_reg        <= '0;
         r_reg        <= RW'(1);
         c_reg        <= CW'(1);
         prod_reg     <= '0;
         wr_r_reg     <= RW'(1);
         wr_c_reg     <= CW'(1);
         wr_valid_reg <= 1'b0;
         done_reg     <= 1'b0;
         f_reg        <= '0;
      end else begin
         done_reg     <= (state_reg == DRAIN);
         wr_valid_reg <= 1'b0;

         if (accept) begin
            a_reg <= a;
            b_reg <= b;
            r_reg <= RW'(1);
            c_reg <= CW'(1);
         end

         // Issue stage: one element into the product register per edge.
         if (state_reg == RUN) begin
            prod_reg     <= res_now;
            wr_r_reg     <= r_reg;
            wr_c_reg     <= c_reg;
            wr_valid_reg <= 1'b1;
            if (c_reg == CW'(COLS)) begin
               c_reg <= CW'(1);
               r_reg <= r_reg + RW'(1);
            end else begin
               c_reg <= c_reg + CW'(1);
            end
         end

         // Write stage trails issue by one edge; the final write lands in DRAIN.
         if (wr_valid_reg) f_reg[wr_r_reg][wr_c_reg] <= prod_reg;
      end
   end

   assign f    = f_reg;
   assign busy = (state_reg != IDLE);
   assign done = done_reg;

endmodule

// File: tb/tb_elem_smul_by_row_seq.sv
// -----------------------------------------------------------------------------
// tb_elem_smul_by_row_seq
//   Directed bench for elem_smul_by_row_seq with ROWS=2, COLS=3, WIDTH=32,
//   SCALE=16. Table of operand/result records plus hand-written sequences for
//   back-to-back operation and reset during an operation.
// -----------------------------------------------------------------------------
module tb_elem_smul_by_row_seq;

   localparam int ROWS  = 2;
   localparam int COLS  = 3;
   localparam int W     = 32;
   localparam int LAT   = ROWS * COLS + 1;

   typedef logic [ROWS:1][COLS:1][W-1:0] mat_t;
   typedef logic [COLS:1][W-1:0]         row_t;

   typedef struct {
      string name;
      mat_t  a;
      row_t  b;
      mat_t  f;
      logic  ovf;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   mat_t a = '0;
   row_t b = '0;
   mat_t f;
   logic busy, done, ovf;

   int total = 0;
   int bad   = 0;

   vec_t vecs[6];

   elem_smul_by_row_seq #(.ROWS(ROWS), .COLS(COLS), .WIDTH(W), .SCALE(16)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .f     (f),
      .busy  (busy),
      .done  (done),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", nm, act, exp);
      end
   endtask

   function automatic mat_t fill_mat(input logic [W-1:0] v);
      mat_t m;
      for (int r = 1; r <= ROWS; r++)
         for (int c = 1; c <= COLS; c++)
            m[r][c] = v;
      return m;
   endfunction

   function automatic row_t fill_row(input logic [W-1:0] v);
      row_t x;
      for (int c = 1; c <= COLS; c++) x[c] = v;
      return x;
   endfunction

   task automatic chk_f(input string nm, input mat_t exp);
      for (int r = 1; r <= ROWS; r++)
         for (int c = 1; c <= COLS; c++)
            chk($sformatf("%s f[%0d][%0d]", nm, r, c), f[r][c], exp[r][c]);
   endtask

   // Wait at negedges for done; returns the number of negedges waited.
   task automatic wait_done(output int n);
      n = 0;
      while (n < 40) begin
         @(negedge clk);
         n++;
         if (done) break;
      end
   endtask

   task automatic run_vec(input vec_t v);
      int n;
      @(negedge clk);
      a = v.a;
      b = v.b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({v.name, " busy after start"}, 32'(busy), 32'd1);
      wait_done(n);
      chk({v.name, " latency"}, 32'(n), 32'(LAT));
      chk_f(v.name, v.f);
      chk({v.name, " ovf"}, 32'(ovf), 32'(v.ovf));
      chk({v.name, " busy in done cycle"}, 32'(busy), 32'd0);
      @(negedge clk);
      chk({v.name, " done single pulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      int n;
      int done_seen;

      // ---------------- vector table
      vecs[0].name = "t1_uniform";
      vecs[0].a    = fill_mat(32'h0001_8000);
      vecs[0].b    = fill_row(32'h0002_0000);
      vecs[0].f    = fill_mat(32'h0003_0000);
      vecs[0].ovf  = 1'b0;

      vecs[1].name = "t2_signed";
      vecs[1].a    = '0;
      vecs[1].a[1][1] = 32'hFFFE_8000;
      vecs[1].a[2][3] = 32'hFFFF_FFFF;
      vecs[1].a[2][1] = 32'h0003_0000;
      vecs[1].b    = '0;
      vecs[1].b[1] = 32'h0000_8000;
      vecs[1].b[3] = 32'h0000_0001;
      vecs[1].f    = '0;
      vecs[1].f[1][1] = 32'hFFFF_4000;
      vecs[1].f[2][3] = 32'hFFFF_FFFF;
      vecs[1].f[2][1] = 32'h0001_8000;
      vecs[1].ovf  = 1'b0;

      vecs[2].name = "t3_pos_ovf";
      vecs[2].a    = '0;
      vecs[2].a[1][2] = 32'h7FFF_0000;
      vecs[2].b    = fill_row(32'h0002_0000);
      vecs[2].f    = '0;
`ifdef ELEM_SMUL_SAT_EN
      vecs[2].f[1][2] = 32'h7FFF_FFFF;
      vecs[2].ovf  = 1'b1;
`else
      vecs[2].f[1][2] = 32'hFFFE_0000;
      vecs[2].ovf  = 1'b0;
`endif

      vecs[3].name = "t4_col_b";
      vecs[3].a    = fill_mat(32'h0001_0000);
      vecs[3].b[1] = 32'h0001_0000;
      vecs[3].b[2] = 32'h0002_0000;
      vecs[3].b[3] = 32'h0003_0000;
      for (int r = 1; r <= ROWS; r++) begin
         vecs[3].f[r][1] = 32'h0001_0000;
         vecs[3].f[r][2] = 32'h0002_0000;
         vecs[3].f[r][3] = 32'h0003_0000;
      end
      vecs[3].ovf  = 1'b0;

      vecs[4].name = "t3_neg_ovf";
      vecs[4].a    = '0;
      vecs[4].a[2][2] = 32'h8000_0000;
      vecs[4].b    = fill_row(32'h0002_0000);
      vecs[4].f    = '0;
`ifdef ELEM_SMUL_SAT_EN
      vecs[4].f[2][2] = 32'h8000_0000;
      vecs[4].ovf  = 1'b1;
`else
      vecs[4].f[2][2] = 32'h0000_0000;
      vecs[4].ovf  = 1'b0;
`endif

      vecs[5] = vecs[3];
      vecs[5].name = "t3_ovf_cleared";

      // ---------------- reset state
      repeat (2) @(negedge clk);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset ovf",  32'(ovf),  32'd0);
      chk_f("reset", '0);
      rst = 1'b0;

      // ---------------- table-driven operations
      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // ---------------- start held high, operands changed mid-op
      @(negedge clk);
      a = fill_mat(32'h0001_8000);
      b = fill_row(32'h0002_0000);
      start = 1'b1;
      @(negedge clk);
      a = fill_mat(32'h0001_0000);
      wait_done(n);
      chk("b2b first latency", 32'(n), 32'(LAT));
      chk_f("b2b first latched a", fill_mat(32'h0003_0000));
      wait_done(n);
      chk("b2b done spacing", 32'(n), 32'(LAT + 1));
      chk_f("b2b second", fill_mat(32'h0002_0000));
      start = 1'b0;
      @(negedge clk);
      chk("b2b idle after drop", 32'(busy), 32'd0);

      // ---------------- reset in the middle of an operation
      @(negedge clk);
      a = vecs[1].a;
      b = vecs[1].b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);     // three elements written by now
      rst = 1'b1;
      #1;
      chk("midrst busy", 32'(busy), 32'd0);
      chk("midrst done", 32'(done), 32'd0);
      chk_f("midrst", '0);
      done_seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      rst = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (done || busy) done_seen++;
      end
      chk("midrst no done", 32'(done_seen), 32'd0);
      run_vec(vecs[3]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
